// File: rtl/ysyx_040729_idu_stage.sv
// Decode stage: input FIFO, registered decode bundle, SYSTEM/illegal drain.
// Define YSYX_040729_RV_M_EN to decode M-extension encodings as legal.
module ysyx_040729_idu_stage #(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int PC_WIDTH   = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  sys_done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PC_WIDTH-1:0]   in_pc,
   input  logic [INST_WIDTH-1:0] in_inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_WIDTH-1:0]   out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [4:0]            rd,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   output logic                  rf_we,
   output logic [2:0]            rf_wdata_src,
   output logic [1:0]            npc_src,
   output logic                  alu_len_dw,
   output logic                  alu_src2_ri,
   output logic                  mem_wen,
   output logic                  mem_ren,
   output logic                  csr_enable,
   output logic                  ecall,
   output logic                  mret,
   output logic                  muldiv,
   output logic                  illegal,
   output logic [DATA_WIDTH-1:0] immediate
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
   localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_SYS = 3'd6;

   logic [PC_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr, rptr;
   logic [CNT_W-1:0]      count;
   logic [0:0]            state;
   logic                  push, pop, head_valid;

   assign head_valid = count != '0;
   assign in_ready   = (count != FULL) && (state == RUN);
   assign push = in_valid && in_ready && !flush;
   assign pop  = head_valid && (!out_valid || out_ready)
              && (state == RUN) && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr]   <= in_pc;
         inst_mem[wptr] <= in_inst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   logic [INST_WIDTH-1:0] hi;
   logic [PC_WIDTH-1:0]   hpc;
   logic [4:0]            opc;
   logic [2:0]            typ, wsrc;
   logic [1:0]            nsrc;
   logic                  known, dw, ren, wen, m_enc, m_bad, d_ill;
   logic                  d_sys, d_mul;
   logic [DATA_WIDTH-1:0] d_imm;

   assign hi  = inst_mem[rptr];
   assign hpc = pc_mem[rptr];
   assign opc = hi[6:2];

   always_comb begin
      typ   = T_R;
      known = 1'b1;
      wsrc  = 3'd0;
      nsrc  = 2'd0;
      dw    = 1'b0;
      ren   = 1'b0;
      wen   = 1'b0;
      m_enc = 1'b0;
      unique case (opc)
         5'b01101: begin typ = T_U; wsrc = 3'd2; end
         5'b00101: begin typ = T_U; wsrc = 3'd4; end
         5'b11011: begin typ = T_J; wsrc = 3'd5; nsrc = 2'd1; end
         5'b11001: begin typ = T_I; wsrc = 3'd5; nsrc = 2'd2; end
         5'b11000: begin typ = T_B; nsrc = 2'd3; end
         5'b00000: begin typ = T_I; wsrc = 3'd1; ren = 1'b1; end
         5'b01000: begin typ = T_S; wen = 1'b1; end
         5'b00100: typ = T_I;
         5'b01100: m_enc = hi[31:25] == 7'b0000001;
         5'b00110: begin typ = T_I; dw = 1'b1; end
         5'b01110: begin dw = 1'b1; m_enc = hi[31:25] == 7'b0000001; end
         5'b11100: typ = T_SYS;
         default:  known = 1'b0;
      endcase
   end

   always_comb begin
      unique case (typ)
         T_I, T_SYS: d_imm = DATA_WIDTH'($signed(hi[31:20]));
         T_S: d_imm = DATA_WIDTH'($signed({hi[31:25], hi[11:7]}));
         T_B: d_imm = DATA_WIDTH'($signed({hi[31], hi[7], hi[30:25],
                                           hi[11:8], 1'b0}));
         T_U: d_imm = DATA_WIDTH'($signed({hi[31:12], 12'b0}));
         T_J: d_imm = DATA_WIDTH'($signed({hi[31], hi[19:12], hi[20],
                                           hi[30:21], 1'b0}));
         default: d_imm = '0;
      endcase
   end

`ifdef YSYX_040729_RV_M_EN
   assign m_bad = 1'b0;
`else
   assign m_bad = m_enc;
`endif

   assign d_ill = (hi[1:0] != 2'b11) || !known || m_bad
               || (dw && (DATA_WIDTH == 32));
   assign d_sys = (typ == T_SYS) && !d_ill;
   assign d_mul = m_enc && !m_bad && !d_ill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_inst     <= '0;
         rd           <= '0;
         rs1          <= '0;
         rs2          <= '0;
         rf_we        <= 1'b0;
         rf_wdata_src <= '0;
         npc_src      <= '0;
         alu_len_dw   <= 1'b0;
         alu_src2_ri  <= 1'b0;
         mem_wen      <= 1'b0;
         mem_ren      <= 1'b0;
         csr_enable   <= 1'b0;
         ecall        <= 1'b0;
         mret         <= 1'b0;
         muldiv       <= 1'b0;
         illegal      <= 1'b0;
         immediate    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (pop) begin
         out_valid    <= 1'b1;
         out_pc       <= hpc;
         out_inst     <= hi;
         rd           <= hi[11:7];
         rs1          <= hi[19:15];
         rs2          <= hi[24:20];
         rf_we        <= !d_ill && (typ != T_S) && (typ != T_B);
         rf_wdata_src <= wsrc;
         npc_src      <= d_ill ? 2'd0 : nsrc;
         alu_len_dw   <= dw;
         alu_src2_ri  <= (typ == T_I) || (typ == T_S) || (typ == T_SYS);
         mem_wen      <= wen && !d_ill;
         mem_ren      <= ren && !d_ill;
         csr_enable   <= d_sys;
         ecall        <= d_sys && (hi[31:7] == 25'h0000000);
         mret         <= d_sys && (hi[31:7] == 25'h0604000);
         muldiv       <= d_mul;
         illegal      <= d_ill;
         immediate    <= d_imm;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Serialise: nothing new issues until the EXU retires the SYSTEM/illegal op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else if (flush)
         state <= RUN;
      else if (state == RUN && pop && (d_sys || d_ill))
         state <= DRAIN;
      else if (state == DRAIN && sys_done)
         state <= RUN;
   end
endmodule

// File: tb/tb_ysyx_040729_idu_stage.sv
// Directed bench for ysyx_040729_idu_stage with an expected-bundle queue.
module tb_ysyx_040729_idu_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0, sys_done = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [63:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [4:0]  rd, rs1, rs2;
   logic        rf_we;
   logic [2:0]  rf_wdata_src;
   logic [1:0]  npc_src;
   logic        alu_len_dw, alu_src2_ri, mem_wen, mem_ren;
   logic        csr_enable, ecall, mret, muldiv, illegal;
   logic [63:0] immediate;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic        we;
      logic        ri;
      logic [63:0] imm;
      logic        ill;
      logic        mul;
      logic        ecall;
      logic [2:0]  wsrc;
      logic [1:0]  npc;
   } exp_t;

   exp_t q[$];

   ysyx_040729_idu_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .sys_done(sys_done),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst),
      .rd(rd), .rs1(rs1), .rs2(rs2),
      .rf_we(rf_we), .rf_wdata_src(rf_wdata_src), .npc_src(npc_src),
      .alu_len_dw(alu_len_dw), .alu_src2_ri(alu_src2_ri),
      .mem_wen(mem_wen), .mem_ren(mem_ren),
      .csr_enable(csr_enable), .ecall(ecall), .mret(mret),
      .muldiv(muldiv), .illegal(illegal), .immediate(immediate)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(
      input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] r,
      input logic we, input logic ri, input logic [63:0] imm,
      input logic ill, input logic mul, input logic ec,
      input logic [2:0] wsrc, input logic [1:0] npc);
      exp_t e;
      e.pc = pc; e.inst = inst; e.rd = r; e.we = we; e.ri = ri;
      e.imm = imm; e.ill = ill; e.mul = mul; e.ecall = ec;
      e.wsrc = wsrc; e.npc = npc;
      return e;
   endfunction

   task automatic send(input exp_t e);
      int w = 0;
      in_valid = 1'b1;
      in_pc    = e.pc;
      in_inst  = e.inst;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_bundle", {32'd0, out_inst}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pc", out_pc, e.pc);
            chk("inst", {32'd0, out_inst}, {32'd0, e.inst});
            chk("rd", {59'd0, rd}, {59'd0, e.rd});
            chk("rf_we", {63'd0, rf_we}, {63'd0, e.we});
            chk("src2_ri", {63'd0, alu_src2_ri}, {63'd0, e.ri});
            chk("imm", immediate, e.imm);
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
            chk("muldiv", {63'd0, muldiv}, {63'd0, e.mul});
            chk("ecall", {63'd0, ecall}, {63'd0, e.ecall});
            chk("wsrc", {61'd0, rf_wdata_src}, {61'd0, e.wsrc});
            chk("npc", {62'd0, npc_src}, {62'd0, e.npc});
         end
      end
   end

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      exp_t mul_e;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
      chk("rst_imm", immediate, 64'd0);

      // latency: accepted at E0, visible after E1
      tick();
      out_ready = 1'b1;
      send(mk(64'h1000, 32'hFFF00093, 5'd1, 1, 1, ONES, 0, 0, 0, 3'd0, 2'd0));
      @(negedge clk);
      chk("lat_e0_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("lat_e1_valid", {63'd0, out_valid}, 64'd1);
      tick();

      // decode patterns streamed back to back
      send(mk(64'h1010, 32'h123450B7, 5'd1, 1, 0, 64'h12345000,
              0, 0, 0, 3'd2, 2'd0));
      send(mk(64'h1014, 32'h008000EF, 5'd1, 1, 0, 64'd8, 0, 0, 0, 3'd5, 2'd1));
      send(mk(64'h1018, 32'hFE000EE3, 5'd29, 0, 0, ONES - 64'd3,
              0, 0, 0, 3'd0, 2'd3));
      send(mk(64'h101C, 32'h0020B823, 5'd16, 0, 1, 64'd16,
              0, 0, 0, 3'd0, 2'd0));
      repeat (3) tick();
      chk("stream_drained", q.size(), 64'd0);

      // backpressure: 1 in output register, 2 in FIFO
      out_ready = 1'b0;
      send(mk(64'h1100, 32'h00100213, 5'd4, 1, 1, 64'd1, 0, 0, 0, 3'd0, 2'd0));
      send(mk(64'h1104, 32'h00200293, 5'd5, 1, 1, 64'd2, 0, 0, 0, 3'd0, 2'd0));
      send(mk(64'h1108, 32'h80000313, 5'd6, 1, 1, ONES - 64'd2047,
              0, 0, 0, 3'd0, 2'd0));
      @(negedge clk);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("full_out_valid", {63'd0, out_valid}, 64'd1);
      chk("full_head_pc", out_pc, 64'h1100);
      tick();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_drained", q.size(), 64'd0);
      chk("bp_out_idle", {63'd0, out_valid}, 64'd0);

      // ecall serialises the following addi until sys_done
      send(mk(64'h2000, 32'h00000073, 5'd0, 1, 1, 64'd0, 0, 0, 1, 3'd0, 2'd0));
      send(mk(64'h2004, 32'h00500113, 5'd2, 1, 1, 64'd5, 0, 0, 0, 3'd0, 2'd0));
      repeat (2) @(negedge clk);
      chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
      chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
      chk("drain_held", q.size(), 64'd1);
      tick();
      sys_done = 1'b1;
      tick();
      sys_done = 1'b0;
      @(negedge clk);
      chk("sysdone_in_ready", {63'd0, in_ready}, 64'd1);
      chk("sysdone_wait", {63'd0, out_valid}, 64'd0);
      tick();
      chk("sysdone_issue", {63'd0, out_valid}, 64'd1);
      tick();
      chk("sysdone_drained", q.size(), 64'd0);

      // mul x3,x1,x2
`ifdef YSYX_040729_RV_M_EN
      mul_e = mk(64'h3000, 32'h022081B3, 5'd3, 1, 0, 64'd0, 0, 1, 0, 3'd0, 2'd0);
`else
      mul_e = mk(64'h3000, 32'h022081B3, 5'd3, 0, 0, 64'd0, 1, 0, 0, 3'd0, 2'd0);
`endif
      send(mul_e);
      tick();
`ifdef YSYX_040729_RV_M_EN
      chk("mul_in_ready", {63'd0, in_ready}, 64'd1);
`else
      chk("mul_in_ready", {63'd0, in_ready}, 64'd0);
`endif
      sys_done = 1'b1;
      tick();
      sys_done = 1'b0;
      chk("mul_drained", q.size(), 64'd0);

      // flush with a full FIFO and a beat presented
      out_ready = 1'b0;
      send(mk(64'h4000, 32'h00100213, 5'd4, 1, 1, 64'd1, 0, 0, 0, 3'd0, 2'd0));
      send(mk(64'h4004, 32'h00200293, 5'd5, 1, 1, 64'd2, 0, 0, 0, 3'd0, 2'd0));
      send(mk(64'h4008, 32'h00300313, 5'd6, 1, 1, 64'd3, 0, 0, 0, 3'd0, 2'd0));
      in_valid = 1'b1;
      in_pc    = 64'h400C;
      in_inst  = 32'h00400393;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_no_output", {63'd0, out_valid}, 64'd0);
      send(mk(64'h5000, 32'h00700413, 5'd8, 1, 1, 64'd7, 0, 0, 0, 3'd0, 2'd0));
      repeat (2) tick();
      chk("flush_recover", q.size(), 64'd0);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      send(mk(64'h6000, 32'h00100213, 5'd4, 1, 1, 64'd1, 0, 0, 0, 3'd0, 2'd0));
      tick();
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      tick();
      rst = 1'b0;
      q.delete();
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
